// File: rtl/divisor_arbiter.sv
// Round-robin sequencer sharing one combinational Divisor between two requesters.
// Operands are held on div_* while the Divisor settles; results return per requester.
module divisor_arbiter #(
   parameter int unsigned NBITS         = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [NBITS-1:0] req0_dividend,
   input  logic [NBITS-1:0] req0_divisor,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [NBITS-1:0] req1_dividend,
   input  logic [NBITS-1:0] req1_divisor,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [NBITS-1:0] rsp0_quotient,
   output logic [NBITS-1:0] rsp0_remainder,
   output logic             rsp0_div_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [NBITS-1:0] rsp1_quotient,
   output logic [NBITS-1:0] rsp1_remainder,
   output logic             rsp1_div_zero,
   output logic [NBITS-1:0] div_dividend,
   output logic [NBITS-1:0] div_divisor,
   input  logic [NBITS-1:0] div_quotient,
   input  logic [NBITS-1:0] div_remainder,
   output logic             busy
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   state_t           state_next;
   logic             last_grant;
   logic             owner;
   logic [CNT_W-1:0] cnt;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             capture;
   logic             rsp_done;
   logic             cap_zero;
   logic [NBITS-1:0] cap_quotient;
   logic [NBITS-1:0] cap_remainder;

   // state register
   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)          state_next = WAIT;
         WAIT:    if (cnt == CNT_LAST) state_next = RESP;
         RESP:    if (rsp_done)        state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   // handshake and control decode; last_grant==1 favours requester 0
   always_comb begin
      grant0     = req0_valid & (~req1_valid | last_grant);
      grant1     = req1_valid & (~req0_valid | ~last_grant);
      req0_ready = (state == IDLE) & grant0;
      req1_ready = (state == IDLE) & grant1;
      accept     = req0_ready | req1_ready;
      capture    = (state == WAIT) && (cnt == CNT_LAST);
      rsp_done   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
      busy       = (state != IDLE);
   end

   // divide-by-zero bypasses the Divisor outputs entirely
   always_comb begin
      cap_zero      = (div_divisor == '0);
      cap_quotient  = cap_zero ? '1 : div_quotient;
      cap_remainder = cap_zero ? div_dividend : div_remainder;
   end

   // operand, arbitration and response registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         cnt            <= '0;
         div_dividend   <= '0;
         div_divisor    <= '0;
         rsp0_valid     <= 1'b0;
         rsp0_quotient  <= '0;
         rsp0_remainder <= '0;
         rsp0_div_zero  <= 1'b0;
         rsp1_valid     <= 1'b0;
         rsp1_quotient  <= '0;
         rsp1_remainder <= '0;
         rsp1_div_zero  <= 1'b0;
      end else begin
         if (accept) begin
            div_dividend <= req1_ready ? req1_dividend : req0_dividend;
            div_divisor  <= req1_ready ? req1_divisor  : req0_divisor;
            owner        <= req1_ready;
            last_grant   <= req1_ready;
            cnt          <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (capture) begin
            if (owner) begin
               rsp1_valid     <= 1'b1;
               rsp1_quotient  <= cap_quotient;
               rsp1_remainder <= cap_remainder;
               rsp1_div_zero  <= cap_zero;
            end else begin
               rsp0_valid     <= 1'b1;
               rsp0_quotient  <= cap_quotient;
               rsp0_remainder <= cap_remainder;
               rsp0_div_zero  <= cap_zero;
            end
         end
         if (rsp_done) begin
            if (owner) rsp1_valid <= 1'b0;
            else       rsp0_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_divisor_arbiter.sv
// Bench for divisor_arbiter: behavioural Divisor, vector table and response scoreboard.
module tb_divisor_arbiter;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
   logic       rsp0_valid, rsp0_ready, rsp0_div_zero;
   logic       rsp1_valid, rsp1_ready, rsp1_div_zero;
   logic [3:0] rsp0_quotient, rsp0_remainder, rsp1_quotient, rsp1_remainder;
   logic [3:0] div_dividend, div_divisor, div_quotient, div_remainder;
   logic       busy;

   always #5 clock = ~clock;

   // shared Divisor; distinctive junk on divide-by-zero must never reach a response
   assign div_quotient  = (div_divisor == 4'd0) ? 4'hA : div_dividend / div_divisor;
   assign div_remainder = (div_divisor == 4'd0) ? 4'h5 : div_dividend % div_divisor;

   divisor_arbiter #(.NBITS(4), .SETTLE_CYCLES(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_quotient(rsp0_quotient), .rsp0_remainder(rsp0_remainder), .rsp0_div_zero(rsp0_div_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_quotient(rsp1_quotient), .rsp1_remainder(rsp1_remainder), .rsp1_div_zero(rsp1_div_zero),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .busy(busy)
   );

   typedef struct {
      int         ch;
      logic [3:0] q;
      logic [3:0] r;
      logic       z;
   } exp_t;

   typedef struct {
      int         ch;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       z;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_check(input int ch, input logic [3:0] q, input logic [3:0] r, input logic z);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected rsp%0d: got q=%0d r=%0d expected no response", ch, q, r);
         return;
      end
      e = sb.pop_front();
      check("rsp channel", ch, e.ch);
      check("rsp quotient", q, e.q);
      check("rsp remainder", r, e.r);
      check("rsp div_zero", z, e.z);
   endtask

   // response monitor: each handshake retires the oldest expected result
   always @(negedge clock) begin
      if (reset_n) begin
         if (rsp0_valid && rsp0_ready) pop_check(0, rsp0_quotient, rsp0_remainder, rsp0_div_zero);
         if (rsp1_valid && rsp1_ready) pop_check(1, rsp1_quotient, rsp1_remainder, rsp1_div_zero);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int ch, input logic v, input logic [3:0] a, input logic [3:0] b);
      if (ch == 0) begin
         req0_valid = v; req0_dividend = a; req0_divisor = b;
      end else begin
         req1_valid = v; req1_dividend = a; req1_divisor = b;
      end
   endtask

   task automatic wait_accept(input int ch, output logic got);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         if ((ch == 0) ? req0_ready : req1_ready) got = 1'b1;
      end
      check("accept seen", 32'(got), 1);
   endtask

   task automatic wait_idle();
      logic idle = 1'b0;
      for (int i = 0; i < 20 && !idle; i++) begin
         @(negedge clock);
         if (!busy) idle = 1'b1;
      end
      check("return to idle", 32'(idle), 1);
   endtask

   task automatic check_reset_outputs();
      check("reset rsp0_valid", rsp0_valid, 0);
      check("reset rsp1_valid", rsp1_valid, 0);
      check("reset rsp0 data", {rsp0_quotient, rsp0_remainder, rsp0_div_zero}, 0);
      check("reset rsp1 data", {rsp1_quotient, rsp1_remainder, rsp1_div_zero}, 0);
      check("reset div operands", {div_dividend, div_divisor}, 0);
      check("reset busy", busy, 0);
   endtask

   task automatic apply_reset();
      tick();
      reset_n = 1'b0;
      set_req(0, 1'b0, 4'd0, 4'd0);
      set_req(1, 1'b0, 4'd0, 4'd0);
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      sb.delete();
      tick();
      reset_n = 1'b1;
   endtask

   // single operation, other requester idle, response consumed immediately
   task automatic do_op(input vec_t v);
      logic got;
      set_req(v.ch, 1'b1, v.a, v.b);
      wait_accept(v.ch, got);
      if (got) sb.push_back('{v.ch, v.q, v.r, v.z});
      tick();
      set_req(v.ch, 1'b0, v.a, v.b);
      @(negedge clock);
      check("rsp not early", (v.ch == 0) ? rsp0_valid : rsp1_valid, 0);
      check("busy while settling", busy, 1);
      @(negedge clock);
      check("rsp latency", (v.ch == 0) ? rsp0_valid : rsp1_valid, 1);
      check("other rsp quiet", (v.ch == 0) ? rsp1_valid : rsp0_valid, 0);
      check("ready low in RESP", {req0_ready, req1_ready}, 0);
      tick();
   endtask

   vec_t tbl[9];
   vec_t p0[2];
   vec_t p1[2];

   initial begin
      logic got;
      int   n;
      int   i0, i1;
      int   order[$];
      int   t_acc[$];

      tbl[0] = '{0, 4'd12, 4'd2, 4'd6,  4'd0, 1'b0};
      tbl[1] = '{1, 4'd9,  4'd0, 4'd15, 4'd9, 1'b1};
      tbl[2] = '{0, 4'd0,  4'd5, 4'd0,  4'd0, 1'b0};
      tbl[3] = '{1, 4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
      tbl[4] = '{0, 4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
      tbl[5] = '{1, 4'd3,  4'd7, 4'd0,  4'd3, 1'b0};
      tbl[6] = '{0, 4'd0,  4'd0, 4'd15, 4'd0, 1'b1};
      tbl[7] = '{1, 4'd14, 4'd4, 4'd3,  4'd2, 1'b0};
      tbl[8] = '{0, 4'd1,  4'd0, 4'd15, 4'd1, 1'b1};
      p0[0]  = '{0, 4'd8,  4'd3, 4'd2,  4'd2, 1'b0};
      p0[1]  = '{0, 4'd11, 4'd5, 4'd2,  4'd1, 1'b0};
      p1[0]  = '{1, 4'd13, 4'd6, 4'd2,  4'd1, 1'b0};
      p1[1]  = '{1, 4'd5,  4'd0, 4'd15, 4'd5, 1'b1};

      reset_n = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      set_req(0, 1'b0, 4'd0, 4'd0);
      set_req(1, 1'b0, 4'd0, 4'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      check("reset ready", {req0_ready, req1_ready}, 0);
      tick();
      reset_n = 1'b1;

      // basic divides, including divide-by-zero on both channels
      foreach (tbl[k]) do_op(tbl[k]);

      // simultaneous requests after reset: requester 0 wins, then 1
      apply_reset();
      set_req(0, 1'b1, 4'd13, 4'd4);
      set_req(1, 1'b1, 4'd15, 4'd2);
      @(negedge clock);
      check("contend req0_ready", req0_ready, 1);
      check("contend req1_ready", req1_ready, 0);
      if (req0_ready) sb.push_back('{0, 4'd3, 4'd1, 1'b0});
      tick();
      set_req(0, 1'b0, 4'd13, 4'd4);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         n++;
         check("rsp1 idle during op0", rsp1_valid, 0);
         if (req1_ready) got = 1'b1;
      end
      check("req1 grant delay", n, 3);
      if (got) sb.push_back('{1, 4'd7, 4'd1, 1'b0});
      tick();
      set_req(1, 1'b0, 4'd15, 4'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rsp0 idle during op1", rsp0_valid, 0);
      end
      wait_idle();

      // response backpressure with requester 1 waiting
      tick();
      rsp0_ready = 1'b0;
      set_req(0, 1'b1, 4'd10, 4'd3);
      wait_accept(0, got);
      if (got) sb.push_back('{0, 4'd3, 4'd1, 1'b0});
      tick();
      set_req(0, 1'b0, 4'd10, 4'd3);
      set_req(1, 1'b1, 4'd6, 4'd2);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         if (rsp0_valid) got = 1'b1;
      end
      check("held rsp0 appears", 32'(got), 1);
      for (int i = 0; i < 5; i++) begin
         check("held rsp0_valid", rsp0_valid, 1);
         check("held rsp0 data", {rsp0_quotient, rsp0_remainder, rsp0_div_zero}, {4'd3, 4'd1, 1'b0});
         check("held readys", {req0_ready, req1_ready}, 0);
         if (i < 4) @(negedge clock);
      end
      tick();
      rsp0_ready = 1'b1;
      @(negedge clock);
      check("req1 blocked in RESP", req1_ready, 0);
      @(negedge clock);
      check("req1 accepted in IDLE", req1_ready, 1);
      if (req1_ready) sb.push_back('{1, 4'd3, 4'd0, 1'b0});
      tick();
      set_req(1, 1'b0, 4'd6, 4'd2);
      wait_idle();

      // reset during WAIT discards the operation
      tick();
      set_req(0, 1'b1, 4'd14, 4'd3);
      wait_accept(0, got);
      tick();
      set_req(0, 1'b0, 4'd14, 4'd3);
      reset_n = 1'b0;
      @(negedge clock);
      check("busy before reset edge", busy, 1);
      @(negedge clock);
      check_reset_outputs();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("no rsp after reset", {rsp0_valid, busy}, 0);
      end
      tick();
      do_op('{0, 4'd7, 4'd7, 4'd1, 4'd0, 1'b0});

      // continuous contention: alternating service, three-cycle accept spacing
      apply_reset();
      i0 = 0;
      i1 = 0;
      set_req(0, 1'b1, p0[0].a, p0[0].b);
      set_req(1, 1'b1, p1[0].a, p1[0].b);
      for (int c = 0; c < 40 && (i0 < 2 || i1 < 2); c++) begin
         @(negedge clock);
         if (req0_ready || req1_ready) check("single grant", req0_ready & req1_ready, 0);
         if (req0_ready) begin
            order.push_back(0);
            t_acc.push_back(c);
            sb.push_back('{0, p0[i0].q, p0[i0].r, p0[i0].z});
            i0++;
            tick();
            if (i0 < 2) set_req(0, 1'b1, p0[i0].a, p0[i0].b);
            else        set_req(0, 1'b0, 4'd0, 4'd0);
         end else if (req1_ready) begin
            order.push_back(1);
            t_acc.push_back(c);
            sb.push_back('{1, p1[i1].q, p1[i1].r, p1[i1].z});
            i1++;
            tick();
            if (i1 < 2) set_req(1, 1'b1, p1[i1].a, p1[i1].b);
            else        set_req(1, 1'b0, 4'd0, 4'd0);
         end
      end
      check("rr accept count", order.size(), 4);
      for (int k = 0; k < order.size(); k++) begin
         check("rr service order", order[k], k % 2);
         if (k > 0) check("rr accept spacing", t_acc[k] - t_acc[k-1], 3);
      end
      wait_idle();
      repeat (2) @(negedge clock);
      check("scoreboard drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
